// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, flag layout and datapath width.
package alu_pkg;
  localparam int ALU_W = 64;

  typedef enum logic [2:0] {
    ALU_LOAD = 3'd0,
    ALU_SUM  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_INC  = 3'd6
  } alu_op_e;

  localparam logic [2:0] FUNCT_ILLEGAL = 3'd7;

  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic equal;
    logic greater;
    logic less;
  } alu_flags_t;

  function automatic logic funct_legal(logic [2:0] f);
    return f != FUNCT_ILLEGAL;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the issue-side requesters and alu_arbiter.
interface alu_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [3*N_REQ-1:0]             req_funct;
  logic [alu_pkg::ALU_W*N_REQ-1:0] req_a;
  logic [alu_pkg::ALU_W*N_REQ-1:0] req_b;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [alu_pkg::ALU_W-1:0]      rsp_result;
  logic [5:0]                     rsp_flags;
  logic                           rsp_err;

  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );
  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_64.sv
// Combinational 64-bit signed ALU; flags compare the operands and describe the result.
module alu_64 import alu_pkg::*; (
  input  alu_op_e                  op,
  input  logic signed [ALU_W-1:0]  a,
  input  logic signed [ALU_W-1:0]  b,
  output logic [ALU_W-1:0]         result,
  output alu_flags_t               flags
);
  logic ovf;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      ALU_LOAD: result = b;
      ALU_SUM: begin
        result = a + b;
        ovf    = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_INC: begin
        result = a + 64'sd1;
        ovf    = !a[ALU_W-1] && result[ALU_W-1];
      end
      default: result = '0;
    endcase
    flags.overflow = ovf;
    flags.negative = result[ALU_W-1];
    flags.zero     = (result == '0);
    flags.equal    = (a == b);
    flags.greater  = (a > b);
    flags.less     = (a < b);
  end
endmodule

// File: rtl/rr_picker.sv
// Round-robin pick: the asserted request at the smallest distance ahead of ptr wins.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  int best_d;
  int d;

  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    best_d = N_REQ;
    d      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - int'(ptr)) % N_REQ;
      if (req[i] && d < best_d) begin
        best_d   = d;
        grant    = '0;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_64 between N_REQ requesters with round-robin grants and a
// one-entry response register that can drain and refill in the same cycle.
module alu_arbiter import alu_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_arbiter_if.slave   bus
);
  logic [ID_W-1:0]  rr_ptr, gnt_idx, ptr_next;
  logic [N_REQ-1:0] gnt_oh;
  logic             gnt_any, slot_free, accept;
  logic [2:0]       funct;
  logic [ALU_W-1:0] opa, opb, alu_res;
  alu_flags_t       alu_flags;

  logic             rsp_valid, rsp_err;
  logic [ID_W-1:0]  rsp_id;
  logic [ALU_W-1:0] rsp_result;
  alu_flags_t       rsp_flags;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign slot_free     = !rsp_valid || bus.rsp_ready;
  // reset gates ready so nothing looks accepted while the register is held clear
  assign accept        = gnt_any && slot_free && !reset;
  assign bus.req_ready = accept ? gnt_oh : '0;

  always_comb begin
    funct = '0;
    opa   = '0;
    opb   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        funct = bus.req_funct[3*i +: 3];
        opa   = bus.req_a[ALU_W*i +: ALU_W];
        opb   = bus.req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  alu_64 u_alu (
    .op     (alu_op_e'(funct)),
    .a      (opa),
    .b      (opb),
    .result (alu_res),
    .flags  (alu_flags)
  );

  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      rr_ptr     <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rr_ptr    <= ptr_next;
      if (funct_legal(funct)) begin
        rsp_result <= alu_res;
        rsp_flags  <= alu_flags;
        rsp_err    <= 1'b0;
      end else begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_flags  = rsp_flags;
  assign bus.rsp_err    = rsp_err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand sequences for contention,
// backpressure and reset, then random traffic against a behavioural model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();
  alu_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // model state
  bit          mvalid;
  int          mid;
  logic [63:0] mres;
  logic [5:0]  mflags;
  bit          merr;
  int          mptr;

  // requester hold tracking
  logic [N-1:0] pend;
  logic [2:0]   p_f [N];
  logic [63:0]  p_a [N];
  logic [63:0]  p_b [N];

  typedef struct {
    int          rq;
    logic [2:0]  f;
    logic [63:0] a, b, res;
    logic [5:0]  fl;
    logic        err;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [5:0] fl, output bit e);
    longint sa, sb;
    logic [64:0] wide;
    bit ov;
    sa = a; sb = b; ov = 0; e = 0; r = '0; wide = '0;
    case (f)
      3'd0: r = b;
      3'd1: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; ov = wide[64] != wide[63]; end
      3'd2: begin wide = {a[63], a} - {b[63], b}; r = wide[63:0]; ov = wide[64] != wide[63]; end
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin wide = {a[63], a} + 65'd1; r = wide[63:0]; ov = wide[64] != wide[63]; end
      default: e = 1;
    endcase
    if (e) fl = '0;
    else   fl = {ov, r[63], r == 64'd0, sa == sb, sa > sb, sa < sb};
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = 64'($urandom_range(0, 40));
      1:       v = {$urandom, $urandom};
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      default: v = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
    endcase
    return v;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b);
    bus.req_valid[i]        = v;
    bus.req_funct[3*i +: 3] = f;
    bus.req_a[64*i +: 64]   = a;
    bus.req_b[64*i +: 64]   = b;
  endtask

  // One clock: check ready against the model, advance the model at the edge,
  // then check the registered response just after it.
  task automatic tick();
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    logic [63:0] r;
    logic [5:0] fl;
    bit e;
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        checks++;
        if (!bus.req_valid[i] || bus.req_funct[3*i +: 3] != p_f[i] ||
            bus.req_a[64*i +: 64] != p_a[i] || bus.req_b[64*i +: 64] != p_b[i]) begin
          errors++;
          $display("FAIL hold_stable req %0d changed while pending", i);
        end
      end
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (g < 0 && bus.req_valid[i]) g = i;
    end
    acc = (g >= 0) && (!mvalid || bus.rsp_ready) && !reset;
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    r = '0; fl = '0; e = 0;
    if (acc) ref_alu(bus.req_funct[3*g +: 3], bus.req_a[64*g +: 64], bus.req_b[64*g +: 64], r, fl, e);
    for (int i = 0; i < N; i++) begin
      pend[i] = bus.req_valid[i] && !(acc && g == i) && !reset;
      p_f[i]  = bus.req_funct[3*i +: 3];
      p_a[i]  = bus.req_a[64*i +: 64];
      p_b[i]  = bus.req_b[64*i +: 64];
    end
    @(posedge clk);
    if (reset) begin
      mvalid = 0; mid = 0; mres = '0; mflags = '0; merr = 0; mptr = 0;
    end else if (acc) begin
      mvalid = 1; mid = g; mres = r; mflags = fl; merr = e; mptr = (g + 1) % N;
    end else if (mvalid && bus.rsp_ready) begin
      mvalid = 0;
    end
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(mvalid));
    if (mvalid || reset) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(mid));
      chk("rsp_result", bus.rsp_result, mres);
      chk("rsp_flags", 64'(bus.rsp_flags), 64'(mflags));
      chk("rsp_err", 64'(bus.rsp_err), 64'(merr));
    end
  endtask

  initial begin
    logic [63:0] sres, ra, rb;
    logic [5:0]  sfl;

    tbl[0] = '{0, 3'd1, 64'd12, 64'd25, 64'd37, 6'b000001, 1'b0};
    tbl[1] = '{1, 3'd2, 64'd12, 64'd25, 64'hFFFF_FFFF_FFFF_FFF3, 6'b010001, 1'b0};
    tbl[2] = '{0, 3'd4, 64'd12, 64'd25, 64'd21, 6'b000001, 1'b0};
    tbl[3] = '{1, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 64'h8000_0000_0000_0002, 6'b110010, 1'b0};
    tbl[4] = '{0, 3'd2, 64'd54, 64'd54, 64'd0, 6'b001100, 1'b0};
    tbl[5] = '{1, 3'd3, 64'hF0F0, 64'hFF00, 64'hF000, 6'b000001, 1'b0};
    tbl[6] = '{0, 3'd5, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010001, 1'b0};
    tbl[7] = '{1, 3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 6'b110010, 1'b0};
    tbl[8] = '{0, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010010, 1'b0};
    tbl[9] = '{1, 3'd7, 64'd99, 64'd1, 64'd0, 6'b000000, 1'b1};

    mvalid = 0; mid = 0; mres = '0; mflags = '0; merr = 0; mptr = 0; pend = '0;
    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_funct = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    // reset state, with requests asserted
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("reset_rsp_result", bus.rsp_result, 64'd0);
    chk("reset_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    reset = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;

    // directed single requests
    foreach (tbl[k]) begin
      bus.req_valid = '0;
      set_req(tbl[k].rq, 1'b1, tbl[k].f, tbl[k].a, tbl[k].b);
      tick();
      chk($sformatf("vec%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("vec%0d_id", k), 64'(bus.rsp_id), 64'(tbl[k].rq));
      chk($sformatf("vec%0d_result", k), bus.rsp_result, tbl[k].res);
      chk($sformatf("vec%0d_flags", k), 64'(bus.rsp_flags), 64'(tbl[k].fl));
      chk($sformatf("vec%0d_err", k), 64'(bus.rsp_err), 64'(tbl[k].err));
      bus.req_valid = '0;
    end

    // contention: grants alternate starting at 0 (last grant was requester 1)
    set_req(0, 1'b1, 3'd2, 64'd12, 64'd25);
    set_req(1, 1'b1, 3'd4, 64'd12, 64'd25);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("cont%0d_id", k), 64'(bus.rsp_id), 64'(k % 2));
      chk($sformatf("cont%0d_result", k), bus.rsp_result,
          (k % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFF3 : 64'd21);
    end

    // backpressure: response held, no grants
    bus.rsp_ready = 1'b0;
    sres = bus.rsp_result;
    sfl  = bus.rsp_flags;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d_ready", k), 64'(bus.req_ready), 64'd0);
      chk($sformatf("bp%0d_result", k), bus.rsp_result, sres);
      chk($sformatf("bp%0d_flags", k), 64'(bus.rsp_flags), 64'(sfl));
      chk($sformatf("bp%0d_id", k), 64'(bus.rsp_id), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.req_ready), 64'b01);
    tick();
    chk("bp_next_id", 64'(bus.rsp_id), 64'd0);
    chk("bp_next_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF3);

    // reset mid-operation: pending response discarded asynchronously
    bus.rsp_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
    mvalid = 0; mid = 0; mres = '0; mflags = '0; merr = 0; mptr = 0; pend = '0;
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_rst_id", 64'(bus.rsp_id), 64'd0);
    chk("post_rst_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF3);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          ra = rand64();
          rb = ($urandom_range(0, 7) == 0) ? ra : rand64();
          set_req(i, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), ra, rb);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
